// File: rtl/alu_muldiv_unit_if.sv
// rtl/alu_muldiv_unit_if.sv - request/response bundle for the RV32M multiply/divide unit
//
// master: decode controls, operands, in_valid, flush, out_ready out; status and result in
// slave : the execute unit side (mirror of master)
interface alu_muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic [1:0]      ALUOp;
   logic [6:0]      op;
   logic [6:0]      funct7;
   logic [2:0]      funct3;
   logic [XLEN-1:0] srcA;
   logic [XLEN-1:0] srcB;
   logic            in_valid;
   logic            in_ready;
   logic            flush;
   logic            md_sel;
   logic            busy;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            div_zero;

   modport master (
      output ALUOp, op, funct7, funct3, srcA, srcB, in_valid, flush, out_ready,
      input  in_ready, md_sel, busy, out_valid, result, div_zero
   );

   modport slave (
      input  ALUOp, op, funct7, funct3, srcA, srcB, in_valid, flush, out_ready,
      output in_ready, md_sel, busy, out_valid, result, div_zero
   );
endinterface

// File: rtl/alu_muldiv_unit.sv
// rtl/alu_muldiv_unit.sv - iterative RV32M multiply/divide execute unit
//
// clk, rst : rising-edge clock, asynchronous active-high reset
// md       : slave side of alu_muldiv_unit_if
//            in : ALUOp/op/funct7/funct3 decode, srcA/srcB, in_valid, flush, out_ready
//            out: in_ready, md_sel, busy, out_valid, result, div_zero
module alu_muldiv_unit #(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1
) (
   input  logic           clk,
   input  logic           rst,
   alu_muldiv_unit_if.slave md
);
   localparam int N  = XLEN / UNROLL;
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0]   LAST    = CW'(N - 1);
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic [2:0]        fn_q, fn_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   opb_q, opb_d;
   // Upper half: product high / partial remainder. Lower half: multiplier / dividend-quotient.
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              out_valid_q, out_valid_d;
   logic              div_zero_q, div_zero_d;

   // ---------------------------------------------------------------- decode
   logic              md_sel;
   logic              unused_op;
   logic              a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic              fast_zero, fast_ovf, accept;

   assign md_sel    = (md.ALUOp == 2'b10) & md.op[5] & (md.funct7 == 7'b0000001);
   assign unused_op = ^{md.op[6], md.op[4:0]};

   // A is unsigned only for MULHU/DIVU/REMU; B additionally unsigned for MULHSU.
   assign a_signed  = ~(md.funct3[0] & (md.funct3[1] | md.funct3[2]));
   assign b_signed  = a_signed & (md.funct3 != 3'b010);
   assign a_neg     = a_signed & md.srcA[XLEN-1];
   assign b_neg     = b_signed & md.srcB[XLEN-1];
   assign a_mag     = a_neg ? -md.srcA : md.srcA;
   assign b_mag     = b_neg ? -md.srcB : md.srcB;

   assign fast_zero = md.funct3[2] & (md.srcB == '0);
   assign fast_ovf  = md.funct3[2] & ~md.funct3[0] & (md.srcA == MIN_INT) & (md.srcB == '1);
   assign accept    = md.in_valid & (state_q == IDLE) & md_sel & ~md.flush;

   // ---------------------------------------------------------------- datapath step
   logic [2*XLEN-1:0] step_acc;
   logic [XLEN+1:0]   trial;
   logic [XLEN:0]     sum;

   always_comb begin
      step_acc = acc_q;
      trial    = '0;
      sum      = '0;
      for (int i = 0; i < UNROLL; i++) begin
         if (fn_q[2]) begin
            // Restoring divide: shift next dividend bit into the remainder, keep if it fits.
            trial = {1'b0, step_acc[2*XLEN-1:XLEN], step_acc[XLEN-1]} - {2'b00, opb_q};
            if (!trial[XLEN+1]) begin
               step_acc = {trial[XLEN-1:0], step_acc[XLEN-2:0], 1'b1};
            end else begin
               step_acc = {step_acc[2*XLEN-2:0], 1'b0};
            end
         end else begin
            // Shift-add: consume multiplier LSB, add multiplicand into the high half.
            sum      = {1'b0, step_acc[2*XLEN-1:XLEN]} + (step_acc[0] ? {1'b0, opb_q} : '0);
            step_acc = {sum, step_acc[XLEN-1:1]};
         end
      end
   end

   // ---------------------------------------------------------------- sign fix / select
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   lo_fix, hi_fix, fix_result;

   always_comb begin
      prod_fix = neg_q ? -acc_q : acc_q;
      lo_fix   = neg_q ? -acc_q[XLEN-1:0]      : acc_q[XLEN-1:0];
      hi_fix   = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      unique case (fn_q)
         3'b000:                 fix_result = prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fix_result = lo_fix;
         default:                fix_result = hi_fix;
      endcase
   end

   // ---------------------------------------------------------------- FSM next state
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      fn_d        = fn_q;
      neg_d       = neg_q;
      opb_d       = opb_q;
      acc_d       = acc_q;
      result_d    = result_q;
      out_valid_d = out_valid_q;
      div_zero_d  = div_zero_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               fn_d  = md.funct3;
               opb_d = b_mag;
               // Remainder takes the dividend sign; everything else takes sA^sB.
               neg_d = (md.funct3[2] & md.funct3[1]) ? a_neg : (a_neg ^ b_neg);
               if (fast_zero) begin
                  result_d    = md.funct3[1] ? md.srcA : '1;
                  div_zero_d  = 1'b1;
                  out_valid_d = 1'b1;
                  state_d     = DONE;
               end else if (fast_ovf) begin
                  result_d    = md.funct3[1] ? '0 : md.srcA;
                  out_valid_d = 1'b1;
                  state_d     = DONE;
               end else begin
                  acc_d   = {{XLEN{1'b0}}, a_mag};
                  count_d = '0;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (md.flush) begin
               state_d = IDLE;
            end else begin
               acc_d   = step_acc;
               count_d = count_q + CW'(1);
               if (count_q == LAST) begin
                  state_d = FIX;
               end
            end
         end
         FIX: begin
            if (md.flush) begin
               state_d = IDLE;
            end else begin
               result_d    = fix_result;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         default: begin
            if (md.flush || md.out_ready) begin
               out_valid_d = 1'b0;
               div_zero_d  = 1'b0;
               state_d     = IDLE;
            end
         end
      endcase
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         fn_q        <= '0;
         neg_q       <= 1'b0;
         opb_q       <= '0;
         acc_q       <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
         div_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         fn_q        <= fn_d;
         neg_q       <= neg_d;
         opb_q       <= opb_d;
         acc_q       <= acc_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
         div_zero_q  <= div_zero_d;
      end
   end

   assign md.md_sel    = md_sel;
   assign md.in_ready  = (state_q == IDLE);
   assign md.busy      = (state_q == CALC) || (state_q == FIX);
   assign md.out_valid = out_valid_q;
   assign md.result    = result_q;
   assign md.div_zero  = div_zero_q;
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// tb/tb_alu_muldiv_unit.sv - directed-vector bench for alu_muldiv_unit (XLEN=32, UNROLL=1)
module tb_alu_muldiv_unit;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   alu_muldiv_unit_if #(.XLEN(32)) md_if ();

   alu_muldiv_unit #(.XLEN(32), .UNROLL(1)) dut (
      .clk (clk),
      .rst (rst),
      .md  (md_if.slave)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      md_if.ALUOp    = 2'b10;
      md_if.op       = 7'b0110011;
      md_if.funct7   = 7'b0000001;
      md_if.funct3   = f3;
      md_if.srcA     = a;
      md_if.srcB     = b;
      md_if.in_valid = 1'b1;
   endtask

   // Called at the first negedge after the accept edge; that sample counts as edge 1.
   task automatic wait_done(output int lat);
      lat = 1;
      while (!md_if.out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic drain(input string tag);
      md_if.out_ready = 1'b1;
      @(negedge clk);
      md_if.out_ready = 1'b0;
      check({tag, "_drain"}, 32'({md_if.out_valid, md_if.in_ready, md_if.div_zero, md_if.busy}),
            32'(4'b0100));
   endtask

   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input logic dz,
                         input int exp_lat);
      int lat;
      drive_req(f3, a, b);
      @(negedge clk);
      // Operands must already be latched; scramble them to prove it.
      md_if.in_valid = 1'b0;
      md_if.srcA     = ~a;
      md_if.srcB     = ~b;
      md_if.funct3   = ~f3;
      wait_done(lat);
      check({tag, "_lat"},   32'(lat), 32'(exp_lat));
      check({tag, "_res"},   md_if.result, exp);
      check({tag, "_dz"},    32'(md_if.div_zero), 32'(dz));
      check({tag, "_inrdy"}, 32'(md_if.in_ready), 32'(0));
      drain(tag);
   endtask

   initial begin
      int lat;
      int seen;

      rst             = 1'b1;
      md_if.ALUOp     = 2'b00;
      md_if.op        = 7'b0;
      md_if.funct7    = 7'b0;
      md_if.funct3    = 3'b0;
      md_if.srcA      = 32'h0;
      md_if.srcB      = 32'h0;
      md_if.in_valid  = 1'b0;
      md_if.flush     = 1'b0;
      md_if.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 32'(md_if.out_valid), 32'(0));
      check("rst_result",    md_if.result, 32'h0);
      check("rst_div_zero",  32'(md_if.div_zero), 32'(0));
      check("rst_busy",      32'(md_if.busy), 32'(0));
      check("rst_in_ready",  32'(md_if.in_ready), 32'(1));

      // md_sel decode and non-M request ignored
      drive_req(3'b000, 32'd3, 32'd4);
      md_if.funct7 = 7'b0000000;
      #1 check("mdsel_f7_zero", 32'(md_if.md_sel), 32'(0));
      repeat (3) @(negedge clk);
      check("ignored_busy",  32'(md_if.busy), 32'(0));
      check("ignored_inrdy", 32'(md_if.in_ready), 32'(1));
      check("ignored_ov",    32'(md_if.out_valid), 32'(0));
      md_if.in_valid = 1'b0;
      md_if.funct7   = 7'b0000001;
      #1 check("mdsel_on", 32'(md_if.md_sel), 32'(1));
      md_if.ALUOp = 2'b00;
      #1 check("mdsel_aluop", 32'(md_if.md_sel), 32'(0));
      @(negedge clk);

      // main function
      run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 34);
      run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 34);
      run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 34);
      run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 34);
      run_op("div",    3'b100, 32'd20,       32'hFFFFFFFA, 32'hFFFFFFFD, 1'b0, 34);
      run_op("rem",    3'b110, 32'hFFFFFFEC, 32'd6,        32'hFFFFFFFE, 1'b0, 34);
      run_op("divu",   3'b101, 32'd20,       32'd6,        32'd3,        1'b0, 34);
      run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        1'b0, 34);
      run_op("div_n7", 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 34);
      // fast paths
      run_op("divu_z", 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1);
      run_op("remu_z", 3'b111, 32'd9,        32'd0,        32'd9,        1'b1, 1);
      run_op("div_ov", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
      run_op("rem_ov", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1);

      // backpressure with a second request waiting
      drive_req(3'b000, 32'd6, 32'd7);
      @(negedge clk);
      md_if.in_valid = 1'b0;
      wait_done(lat);
      check("bp_lat", 32'(lat), 32'(34));
      drive_req(3'b101, 32'd20, 32'd6);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_res",   md_if.result, 32'd42);
         check("bp_ov",    32'(md_if.out_valid), 32'(1));
         check("bp_inrdy", 32'(md_if.in_ready), 32'(0));
      end
      md_if.out_ready = 1'b1;
      @(negedge clk);
      md_if.out_ready = 1'b0;
      check("bp_drain_ov",    32'(md_if.out_valid), 32'(0));
      check("bp_drain_inrdy", 32'(md_if.in_ready), 32'(1));
      check("bp_drain_busy",  32'(md_if.busy), 32'(0));
      @(negedge clk);
      check("bp_second_busy", 32'(md_if.busy), 32'(1));
      md_if.in_valid = 1'b0;
      wait_done(lat);
      check("bp_second_lat", 32'(lat), 32'(34));
      check("bp_second_res", md_if.result, 32'd3);
      drain("bp_second");

      // flush at CALC count 10
      drive_req(3'b101, 32'd1000, 32'd3);
      @(negedge clk);
      md_if.in_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("fl_busy_before", 32'(md_if.busy), 32'(1));
      md_if.flush = 1'b1;
      @(negedge clk);
      md_if.flush = 1'b0;
      check("fl_busy",  32'(md_if.busy), 32'(0));
      check("fl_inrdy", 32'(md_if.in_ready), 32'(1));
      check("fl_ov",    32'(md_if.out_valid), 32'(0));
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (md_if.out_valid) seen++;
      end
      check("fl_no_result", 32'(seen), 32'(0));

      // flush in IDLE blocks accept
      drive_req(3'b000, 32'd2, 32'd2);
      md_if.flush = 1'b1;
      @(negedge clk);
      md_if.flush    = 1'b0;
      md_if.in_valid = 1'b0;
      check("fl_idle_busy", 32'(md_if.busy), 32'(0));
      check("fl_idle_ov",   32'(md_if.out_valid), 32'(0));

      // async reset mid-CALC
      drive_req(3'b000, 32'd3, 32'd5);
      @(negedge clk);
      md_if.in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check("arst_busy",   32'(md_if.busy), 32'(0));
      check("arst_ov",     32'(md_if.out_valid), 32'(0));
      check("arst_result", md_if.result, 32'h0);
      check("arst_dz",     32'(md_if.div_zero), 32'(0));
      check("arst_inrdy",  32'(md_if.in_ready), 32'(1));
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (md_if.out_valid) seen++;
      end
      check("arst_no_result", 32'(seen), 32'(0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
